// File: rtl/spi_slave_rx.sv
// SPI receiver: oversamples sclk/cs/mosi on clk and rebuilds DATA_W-bit frames.
// Samples on falling sclk; flags frames that cs truncates early.
module spi_slave_rx #(
  parameter int DATA_W      = 12,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy,
  output logic              frame_err
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [SYNC_STAGES-1:0] r_sclk_q;
  logic [SYNC_STAGES-1:0] r_cs_q;
  logic [SYNC_STAGES-1:0] r_mosi_q;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_bitcnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_dout;
  logic              r_done;
  logic              r_busy;
  logic              r_ferr;

  logic              w_sclk_s;
  logic              w_cs_s;
  logic              w_mosi_s;
  logic              w_fall;
  logic              w_cs_rise;
  logic              w_last;
  logic [DATA_W-1:0] w_next;

  // Equal-depth chains keep the three pins aligned with each other
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_q    <= '0;
      r_cs_q      <= '1;
      r_mosi_q    <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_q    <= {r_sclk_q[SYNC_STAGES-2:0], sclk};
      r_cs_q      <= {r_cs_q[SYNC_STAGES-2:0], cs};
      r_mosi_q    <= {r_mosi_q[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  assign w_sclk_s  = r_sclk_q[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_q[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_q[SYNC_STAGES-1];
  assign w_fall    = r_sclk_prev & ~w_sclk_s;
  assign w_cs_rise = ~r_cs_prev & w_cs_s;
  assign w_last    = (r_bitcnt == LAST);

  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_next = {w_mosi_s, r_shreg[DATA_W-1:1]};
    end else begin : g_msb
      assign w_next = {r_shreg[DATA_W-2:0], w_mosi_s};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_dout   <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_cs_s) begin
            r_state  <= S_SHIFT;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_SHIFT: begin
          // The sample wins over a coincident cs rise
          if (w_fall) begin
            r_shreg  <= w_next;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (w_last) begin
              r_dout  <= w_next;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= w_cs_rise ? S_IDLE : S_WAIT;
            end else if (w_cs_rise) begin
              r_ferr  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (w_cs_rise) begin
            r_ferr  <= (r_bitcnt != '0);
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout      = r_dout;
  assign done      = r_done;
  assign busy      = r_busy;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: LSB- and MSB-first instances share one SPI bus;
// a queue-based scoreboard checks every done/frame_err event.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic [11:0] dout_l, dout_m;
  logic        done_l, done_m;
  logic        busy_l, busy_m;
  logic        ferr_l, ferr_m;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(12), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) u_lsb (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout_l), .done(done_l), .busy(busy_l), .frame_err(ferr_l)
  );

  spi_slave_rx #(.DATA_W(12), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) u_msb (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout_m), .done(done_m), .busy(busy_m), .frame_err(ferr_m)
  );

  typedef struct {
    bit          is_err;
    logic [11:0] data;
    int          at;
  } ev_t;

  ev_t         q[2][$];
  logic [11:0] last[2];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: bit i of the stream lands at dout[i] (LSB) or dout[11-i] (MSB)
  function automatic logic [11:0] word_of(bit [15:0] b, bit lsb);
    logic [11:0] w;
    w = '0;
    for (int i = 0; i < 12; i++) begin
      if (lsb) w[i] = b[i];
      else     w[11-i] = b[i];
    end
    return w;
  endfunction

  task automatic push_done(bit [15:0] b, int at);
    for (int d = 0; d < 2; d++) begin
      last[d] = word_of(b, d == 0);
      q[d].push_back('{1'b0, last[d], at});
    end
  endtask

  task automatic push_err(int at);
    for (int d = 0; d < 2; d++) q[d].push_back('{1'b1, last[d], at});
  endtask

  // Master model: mosi changes with rising sclk, 10 clk per sclk phase
  task automatic frame(bit [15:0] b, int n, bit simul, int gap);
    int p;
    cs = 1'b0;
    ticks(10);
    for (int i = 0; i < n; i++) begin
      if (i == 1) begin
        chk("busy_mid_lsb", busy_l, 1);
        chk("busy_mid_msb", busy_m, 1);
      end
      sclk = 1'b1;
      mosi = b[i];
      ticks(10);
      sclk = 1'b0;
      p = cyc;
      if (i == 11) push_done(b, p + 3);
      if (i == n - 1 && simul) begin
        cs = 1'b1;
        if (n < 12) push_err(p + 3);
      end else begin
        ticks(10);
      end
    end
    if (!(simul && n > 0)) begin
      if (n >= 12) begin
        chk("busy_after_lsb", busy_l, 0);
        chk("busy_after_msb", busy_m, 0);
      end
      cs = 1'b1;
      p  = cyc;
      if (n >= 1 && n < 12) push_err(p + 3);
    end
    ticks(gap);
  endtask

  function automatic bit [15:0] rev12(logic [11:0] x);
    bit [15:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r[i] = x[11-i];
    return r;
  endfunction

  logic [1:0]  dn, er;
  logic [11:0] dv[2];
  assign dn    = {done_m, done_l};
  assign er    = {ferr_m, ferr_l};
  assign dv[0] = dout_l;
  assign dv[1] = dout_m;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        if (dn[i] || er[i]) begin
          if (q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event dut%0d done=%0b err=%0b required=none",
                     i, dn[i], er[i]);
          end else begin
            ev_t e;
            e = q[i].pop_front();
            chk($sformatf("ev_err_dut%0d", i), er[i], e.is_err);
            chk($sformatf("ev_done_dut%0d", i), dn[i], !e.is_err);
            chk($sformatf("ev_dout_dut%0d", i), dv[i], e.data);
            chk($sformatf("ev_cycle_dut%0d", i), cyc, e.at);
          end
        end
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_dout_l"}, dout_l, 0);
    chk({tag, "_dout_m"}, dout_m, 0);
    chk({tag, "_done_l"}, done_l, 0);
    chk({tag, "_done_m"}, done_m, 0);
    chk({tag, "_busy_l"}, busy_l, 0);
    chk({tag, "_busy_m"}, busy_m, 0);
    chk({tag, "_ferr_l"}, ferr_l, 0);
    chk({tag, "_ferr_m"}, ferr_m, 0);
  endtask

  initial begin
    rst     = 1'b0;
    cs      = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    last[0] = '0;
    last[1] = '0;
    ticks(3);
    chk_zero("reset");
    rst = 1'b1;
    ticks(5);

    // MSB-first stream 1,0,1,0,1,0,1,1,1,1,0,0
    frame(rev12(12'hABC), 12, 1'b0, 10);
    // Nominal LSB-first ABC
    frame({4'h0, 12'hABC}, 12, 1'b0, 10);
    // Abort after 5 bits, dout must hold
    frame({4'h0, 12'h5A5}, 5, 1'b0, 10);
    chk("abort_hold_lsb", dout_l, 12'hABC);
    frame({4'h0, 12'h5A5}, 12, 1'b0, 10);
    // Back-to-back with minimum cs gap
    frame({4'h0, 12'h123}, 12, 1'b0, 4);
    frame({4'h0, 12'hFED}, 12, 1'b0, 10);
    // Overlong
    frame(16'hC7E1, 14, 1'b0, 10);
    // Simultaneous last fall and cs rise
    frame(16'h0963, 12, 1'b1, 10);
    frame(16'h0041, 5, 1'b1, 10);
    // Empty cs window
    frame(16'h0000, 0, 1'b0, 10);

    // Reset mid-frame after 6 bits
    cs = 1'b0;
    ticks(10);
    for (int i = 0; i < 6; i++) begin
      sclk = 1'b1;
      mosi = 1'($urandom);
      ticks(10);
      sclk = 1'b0;
      ticks(10);
    end
    chk("busy_prereset_lsb", busy_l, 1);
    rst = 1'b0;
    ticks(1);
    chk_zero("midreset");
    ticks(2);
    last[0] = '0;
    last[1] = '0;
    rst = 1'b1;
    ticks(10);
    cs = 1'b1;
    ticks(10);
    frame({4'h0, 12'h0F0}, 12, 1'b0, 10);

    for (int t = 0; t < 20; t++) begin
      frame(16'($urandom), $urandom_range(0, 14),
            1'($urandom_range(0, 1)), $urandom_range(4, 8));
    end

    for (int k = 0; k < 100 && (q[0].size() + q[1].size()) > 0; k++) ticks(1);
    chk("queue_drained", q[0].size() + q[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
